// File: rtl/udp_rx_pkg.sv
// Shared constants, FSM state type and byte-select helpers for the UDP/MII receive path.
package udp_rx_pkg;

   localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
   localparam logic [7:0]  IP_VER_IHL    = 8'h45;
   localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;
   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;

   localparam logic [15:0] ETH_HEAD_LEN = 16'd14;
   localparam logic [15:0] IP_HEAD_LEN  = 16'd20;
   localparam logic [15:0] UDP_HEAD_LEN = 16'd8;

   localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

   typedef enum logic [2:0] {
      StIdle, StPreamble, StEthHead, StIpHead, StUdpHead, StData, StWaitEnd
   } rx_state_e;

   // Byte idx of a big-endian field, idx 0 = most significant byte.
   function automatic logic [7:0] be_byte48(input logic [47:0] v, input logic [2:0] idx);
      logic [47:0] s;
      s = v << {idx, 3'b000};
      return s[47:40];
   endfunction

   function automatic logic [7:0] be_byte32(input logic [31:0] v, input logic [1:0] idx);
      logic [31:0] s;
      s = v << {idx, 3'b000};
      return s[31:24];
   endfunction

endpackage

// File: rtl/crc32_nibble.sv
// Ethernet CRC-32, one MII nibble per enabled cycle (bit 0 first), preset to all ones on clear.
module crc32_nibble (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        en,
   input  logic        clr,
   input  logic [3:0]  data,
   output logic [31:0] crc
);

   logic [31:0] crc_d;

   always_comb begin
      crc_d = crc;
      for (int i = 0; i < 4; i++) begin
         if (crc_d[31] ^ data[i]) crc_d = {crc_d[30:0], 1'b0} ^ 32'h04C11DB7;
         else                     crc_d = {crc_d[30:0], 1'b0};
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst)  crc <= 32'hFFFF_FFFF;
      else if (clr) crc <= 32'hFFFF_FFFF;
      else if (en)  crc <= crc_d;
   end

endmodule

// File: rtl/udp_mii_receive.sv
// MII receive parser: Ethernet/IPv4/UDP header checks, payload out as 32-bit big-endian words.
// Define RX_FCS_CHECK_EN to verify the Ethernet FCS at the end of each frame.
module udp_mii_receive
   import udp_rx_pkg::*;
#(
   parameter logic [47:0] BOARD_MAC = 48'h12_34_56_78_9A_BC,
   parameter logic [31:0] BOARD_IP  = {8'd169, 8'd254, 8'd1, 8'd23}
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        eth_rxdv,
   input  logic [3:0]  eth_rx_data,
   output logic        rec_data_en,
   output logic [31:0] rec_data,
   output logic        rec_end,
   output logic [15:0] rec_data_num,
   output logic        err_flag
);

   rx_state_e   state_q, state_d;
   logic        nib_hi_q;
   logic [3:0]  nib_lo_q;
   logic [15:0] cnt_q, cnt_d;
   logic        dst_uni_q, dst_uni_d, dst_bc_q, dst_bc_d;
   logic [7:0]  len_hi_q, len_hi_d;
   logic        rec_data_en_d, rec_end_d, err_d;
   logic [31:0] rec_data_d;
   logic [15:0] rec_num_d;
   logic        byte_vld, bad, fcs_bad;
   logic [7:0]  rx_byte;

   assign rx_byte  = {eth_rx_data, nib_lo_q};
   assign byte_vld = eth_rxdv & nib_hi_q;

`ifdef RX_FCS_CHECK_EN
   logic [31:0] crc;
   logic        crc_en, crc_clr;

   assign crc_clr = (state_q == StPreamble) && byte_vld && (rx_byte == SFD_BYTE);
   assign crc_en  = eth_rxdv && (state_q inside {StEthHead, StIpHead, StUdpHead, StData,
                                                 StWaitEnd});
   assign fcs_bad = (crc != CRC_RESIDUE);

   crc32_nibble u_crc32_nibble (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .en      (crc_en),
      .clr     (crc_clr),
      .data    (eth_rx_data),
      .crc     (crc)
   );
`else
   assign fcs_bad = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      dst_uni_d     = dst_uni_q;
      dst_bc_d      = dst_bc_q;
      len_hi_d      = len_hi_q;
      rec_data_en_d = 1'b0;
      rec_end_d     = 1'b0;
      rec_data_d    = rec_data;
      rec_num_d     = rec_data_num;
      err_d         = err_flag;
      bad           = 1'b0;
      case (state_q)
         StIdle: begin
            if (byte_vld && rx_byte == PREAMBLE_BYTE) begin
               state_d = StPreamble;
               cnt_d   = 16'd1;
            end
         end
         StPreamble: begin
            if (!eth_rxdv) begin
               state_d = StIdle;
            end else if (byte_vld) begin
               if (rx_byte == PREAMBLE_BYTE) begin
                  if (cnt_q < 16'd7) cnt_d = cnt_q + 16'd1;
               end else if (rx_byte == SFD_BYTE && cnt_q >= 16'd6) begin
                  state_d   = StEthHead;
                  cnt_d     = '0;
                  err_d     = 1'b0;
                  dst_uni_d = 1'b1;
                  dst_bc_d  = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StEthHead, StIpHead, StUdpHead, StData: begin
            if (!eth_rxdv) begin
               // Frame ended before the payload was complete.
               err_d   = 1'b1;
               state_d = StIdle;
            end else if (byte_vld) begin
               cnt_d = cnt_q + 16'd1;
               if (state_q == StEthHead) begin
                  if (cnt_q < 16'd6) begin
                     dst_uni_d = dst_uni_q & (rx_byte == be_byte48(BOARD_MAC, cnt_q[2:0]));
                     dst_bc_d  = dst_bc_q & (rx_byte == 8'hFF);
                  end
                  if (cnt_q == 16'd5)  bad = !(dst_uni_d || dst_bc_d);
                  if (cnt_q == 16'd12) bad = (rx_byte != ETH_TYPE_IPV4[15:8]);
                  if (cnt_q == ETH_HEAD_LEN - 16'd1) begin
                     bad     = (rx_byte != ETH_TYPE_IPV4[7:0]);
                     state_d = StIpHead;
                     cnt_d   = '0;
                  end
               end else if (state_q == StIpHead) begin
                  if (cnt_q == 16'd0) bad = (rx_byte != IP_VER_IHL);
                  if (cnt_q == 16'd9) bad = (rx_byte != IP_PROTO_UDP);
                  if (cnt_q >= 16'd16) bad = (rx_byte != be_byte32(BOARD_IP, cnt_q[1:0]));
                  if (cnt_q == IP_HEAD_LEN - 16'd1) begin
                     state_d = StUdpHead;
                     cnt_d   = '0;
                  end
               end else if (state_q == StUdpHead) begin
                  if (cnt_q == 16'd4) len_hi_d = rx_byte;
                  if (cnt_q == 16'd5) begin
                     if ({len_hi_q, rx_byte} < UDP_HEAD_LEN) bad = 1'b1;
                     else rec_num_d = {len_hi_q, rx_byte} - UDP_HEAD_LEN;
                  end
                  if (cnt_q == UDP_HEAD_LEN - 16'd1) begin
                     cnt_d = '0;
                     if (rec_data_num == 16'd0) begin
                        rec_end_d = 1'b1;
                        state_d   = StWaitEnd;
                     end else begin
                        state_d = StData;
                     end
                  end
               end else begin
                  // Writing byte 0 clears the rest, so a short final word is zero-filled.
                  unique case (cnt_q[1:0])
                     2'd0: rec_data_d        = {rx_byte, 24'h0};
                     2'd1: rec_data_d[23:16] = rx_byte;
                     2'd2: rec_data_d[15:8]  = rx_byte;
                     2'd3: rec_data_d[7:0]   = rx_byte;
                  endcase
                  if (cnt_d == rec_data_num) begin
                     rec_data_en_d = 1'b1;
                     rec_end_d     = 1'b1;
                     state_d       = StWaitEnd;
                  end else if (cnt_q[1:0] == 2'd3) begin
                     rec_data_en_d = 1'b1;
                  end
               end
               if (bad) begin
                  err_d   = 1'b1;
                  state_d = StWaitEnd;
               end
            end
         end
         StWaitEnd: begin
            if (!eth_rxdv) begin
               state_d = StIdle;
               if (fcs_bad) err_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q      <= StIdle;
         nib_hi_q     <= 1'b0;
         nib_lo_q     <= '0;
         cnt_q        <= '0;
         dst_uni_q    <= 1'b0;
         dst_bc_q     <= 1'b0;
         len_hi_q     <= '0;
         rec_data_en  <= 1'b0;
         rec_data     <= '0;
         rec_end      <= 1'b0;
         rec_data_num <= '0;
         err_flag     <= 1'b0;
      end else begin
         state_q      <= state_d;
         nib_hi_q     <= eth_rxdv & ~nib_hi_q;
         if (eth_rxdv && !nib_hi_q) nib_lo_q <= eth_rx_data;
         cnt_q        <= cnt_d;
         dst_uni_q    <= dst_uni_d;
         dst_bc_q     <= dst_bc_d;
         len_hi_q     <= len_hi_d;
         rec_data_en  <= rec_data_en_d;
         rec_data     <= rec_data_d;
         rec_end      <= rec_end_d;
         rec_data_num <= rec_num_d;
         err_flag     <= err_d;
      end
   end

endmodule

// File: tb/tb_udp_mii_receive.sv
// Directed frame bench with a byte-level frame model and a per-cycle output checker.
module tb_udp_mii_receive;
   import udp_rx_pkg::*;

   localparam logic [47:0] MAC = 48'h12_34_56_78_9A_BC;
   localparam logic [31:0] IP  = {8'd169, 8'd254, 8'd1, 8'd23};

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic        eth_rxdv;
   logic [3:0]  eth_rx_data;
   logic        rec_data_en;
   logic [31:0] rec_data;
   logic        rec_end;
   logic [15:0] rec_data_num;
   logic        err_flag;

   udp_mii_receive #(.BOARD_MAC(MAC), .BOARD_IP(IP)) dut (
      .sys_clk      (sys_clk),
      .sys_rst      (sys_rst),
      .eth_rxdv     (eth_rxdv),
      .eth_rx_data  (eth_rx_data),
      .rec_data_en  (rec_data_en),
      .rec_data     (rec_data),
      .rec_end      (rec_end),
      .rec_data_num (rec_data_num),
      .err_flag     (err_flag)
   );

   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] word;
      int          at;
      bit          has_word;
      bit          last;
   } exp_t;

   exp_t        exq[$];
   logic [7:0]  fr[$];
   int          total = 0;
   int          bad = 0;
   int          n_en = 0;
   int          n_end = 0;
   logic [31:0] first_word, last_word;
   bit          m_due, m_en, m_end;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Per-cycle checker against the expectation queue.
   always @(negedge sys_clk) begin
      if (!sys_rst) begin
         m_due = (exq.size() > 0) && (exq[0].at == cyc);
         m_en  = m_due && exq[0].has_word;
         m_end = m_due && exq[0].last;
         check("rec_data_en", 32'(rec_data_en), 32'(m_en));
         check("rec_end", 32'(rec_end), 32'(m_end));
         if (m_en) check("rec_data", rec_data, exq[0].word);
         if (rec_data_en) begin
            if (n_en == 0) first_word = rec_data;
            last_word = rec_data;
            n_en++;
         end
         if (rec_end) n_end++;
         if (m_due) void'(exq.pop_front());
      end
   end

   function automatic logic [31:0] fcs_of(input int from);
      logic [31:0] c;
      logic [7:0]  d;
      c = 32'hFFFF_FFFF;
      for (int i = from; i < fr.size(); i++) begin
         d = fr[i];
         for (int b = 0; b < 8; b++) begin
            if (c[0] ^ d[b]) c = (c >> 1) ^ 32'hEDB8_8320;
            else             c = c >> 1;
         end
      end
      return ~c;
   endfunction

   // cut = number of frame bytes sent before eth_rxdv drops (0 = whole frame).
   task automatic send_frame(input logic [47:0] dst, input logic [7:0] proto, input int n,
                             input logic [7:0] base, input int cut, input bit chk_sfd_clr);
      logic [47:0] src;
      logic [15:0] ip_len, udp_len;
      logic [31:0] fcs, w;
      int          s, sent, last_b, exp_words;
      bit          acc, exp_err, exp_done;
      src     = 48'h00_0A_35_01_FE_C0;
      ip_len  = 16'(28 + n);
      udp_len = 16'(8 + n);
      fr.delete();
      repeat (7) fr.push_back(8'h55);
      fr.push_back(8'hD5);
      for (int i = 0; i < 6; i++) fr.push_back(dst[47 - 8*i -: 8]);
      for (int i = 0; i < 6; i++) fr.push_back(src[47 - 8*i -: 8]);
      fr.push_back(8'h08); fr.push_back(8'h00);
      fr.push_back(8'h45); fr.push_back(8'h00);
      fr.push_back(ip_len[15:8]); fr.push_back(ip_len[7:0]);
      fr.push_back(8'h00); fr.push_back(8'h00); fr.push_back(8'h40); fr.push_back(8'h00);
      fr.push_back(8'h40); fr.push_back(proto); fr.push_back(8'h00); fr.push_back(8'h00);
      fr.push_back(8'hC0); fr.push_back(8'hA8); fr.push_back(8'h01); fr.push_back(8'h66);
      for (int i = 0; i < 4; i++) fr.push_back(IP[31 - 8*i -: 8]);
      fr.push_back(8'h04); fr.push_back(8'hD2); fr.push_back(8'h04); fr.push_back(8'hD2);
      fr.push_back(udp_len[15:8]); fr.push_back(udp_len[7:0]);
      fr.push_back(8'h00); fr.push_back(8'h00);
      for (int j = 0; j < n; j++) fr.push_back(base + 8'(j));
      while (fr.size() < 68) fr.push_back(8'h00);
      fcs = fcs_of(8);
      for (int i = 0; i < 4; i++) fr.push_back(fcs[8*i +: 8]);
      sent = (cut == 0) ? fr.size() : cut;

      @(posedge sys_clk); #1;
      s = cyc;
      n_en = 0;
      n_end = 0;
      // Payload byte j is frame byte 50+j; its word appears one cycle after its high nibble.
      acc       = (dst == MAC || dst == 48'hFFFF_FFFF_FFFF) && proto == 8'd17;
      exp_done  = acc && sent >= 50 + n;
      exp_err   = !acc || sent < 50 + n;
      exp_words = 0;
      if (acc && n == 0 && sent >= 50) exq.push_back('{32'h0, s + 100, 1'b0, 1'b1});
      if (acc) begin
         for (int wi = 0; 4*wi < n; wi++) begin
            last_b = (4*wi + 3 < n) ? 4*wi + 3 : n - 1;
            w = '0;
            for (int b = 4*wi; b < 4*wi + 4; b++) w = (w << 8) | ((b < n) ? 32'(base + 8'(b)) : 0);
            if (50 + last_b < sent) begin
               exq.push_back('{w, s + 2*(50 + last_b) + 2, 1'b1, (last_b == n - 1)});
               exp_words++;
            end
         end
      end

      for (int k = 0; k < 2*sent; k++) begin
         if (k > 0) begin
            @(posedge sys_clk); #1;
         end
         if (chk_sfd_clr && k == 15) check("err_before_sfd", 32'(err_flag), 32'd1);
         if (chk_sfd_clr && k == 16) check("err_clear_at_sfd", 32'(err_flag), 32'd0);
         eth_rxdv    = 1'b1;
         eth_rx_data = k[0] ? fr[k/2][7:4] : fr[k/2][3:0];
      end
      @(posedge sys_clk); #1;
      eth_rxdv    = 1'b0;
      eth_rx_data = 4'h0;
      repeat (12) @(posedge sys_clk);
      #1;
      check("word_count", 32'(n_en), 32'(exp_words));
      check("end_count", 32'(n_end), 32'(exp_done));
      check("err_flag", 32'(err_flag), 32'(exp_err));
      check("expectations_left", 32'(exq.size()), 32'd0);
      if (exp_done) check("rec_data_num", 32'(rec_data_num), 32'(n));
      exq.delete();
   endtask

   initial begin
      sys_rst     = 1'b1;
      eth_rxdv    = 1'b0;
      eth_rx_data = 4'h0;
      repeat (3) @(posedge sys_clk);
      #1;
      check("rst_rec_data_en", 32'(rec_data_en), 32'd0);
      check("rst_rec_data", rec_data, 32'd0);
      check("rst_rec_end", 32'(rec_end), 32'd0);
      check("rst_rec_data_num", 32'(rec_data_num), 32'd0);
      check("rst_err_flag", 32'(err_flag), 32'd0);
      sys_rst = 1'b0;
      repeat (4) @(posedge sys_clk);

      // 17-byte payload A0..B0: five words, last one B0000000.
      send_frame(MAC, 8'd17, 17, 8'hA0, 0, 1'b0);
      check("f1_words", 32'(n_en), 32'd5);
      check("f1_first_word", first_word, 32'hA0A1_A2A3);
      check("f1_last_word", last_word, 32'hB000_0000);
      check("f1_num", 32'(rec_data_num), 32'd17);
      check("f1_err", 32'(err_flag), 32'd0);

      // Zero-length payload.
      send_frame(MAC, 8'd17, 0, 8'h00, 0, 1'b0);
      check("f2_words", 32'(n_en), 32'd0);
      check("f2_end", 32'(n_end), 32'd1);
      check("f2_num", 32'(rec_data_num), 32'd0);

      // Wrong destination MAC, then a good frame clears err_flag at its SFD.
      send_frame(48'h1C_2B_3A_49_58_67, 8'd17, 12, 8'h10, 0, 1'b0);
      check("f3_err", 32'(err_flag), 32'd1);
      check("f3_end", 32'(n_end), 32'd0);
      send_frame(MAC, 8'd17, 4, 8'h20, 0, 1'b1);
      check("f4_word", last_word, 32'h2021_2223);

      // TCP protocol byte.
      send_frame(MAC, 8'd6, 12, 8'h30, 0, 1'b0);
      check("f5_err", 32'(err_flag), 32'd1);
      check("f5_words", 32'(n_en), 32'd0);

      // Asynchronous reset between clock edges.
      @(posedge sys_clk); #2;
      sys_rst = 1'b1;
      #1;
      check("async_rst_err", 32'(err_flag), 32'd0);
      check("async_rst_num", 32'(rec_data_num), 32'd0);
      #1;
      sys_rst = 1'b0;
      repeat (3) @(posedge sys_clk);

      // Broadcast destination, 8-byte payload.
      send_frame(48'hFFFF_FFFF_FFFF, 8'd17, 8, 8'h50, 0, 1'b0);
      check("f6_words", 32'(n_en), 32'd2);
      check("f6_num", 32'(rec_data_num), 32'd8);
      check("f6_last_word", last_word, 32'h5455_5657);

      // eth_rxdv drops after two of twelve payload bytes.
      send_frame(MAC, 8'd17, 12, 8'h60, 52, 1'b0);
      check("f7_err", 32'(err_flag), 32'd1);
      check("f7_end", 32'(n_end), 32'd0);
      check("f7_idle", 32'(dut.state_q), 32'(StIdle));

      // Receiver still takes a good frame afterwards.
      send_frame(MAC, 8'd17, 5, 8'h70, 0, 1'b0);
      check("f8_last_word", last_word, 32'h7400_0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
